// File: rtl/mmio_map_pkg.sv
// Mailbox address map and monitor state encoding shared by the path monitor
// and anything else that needs to decode the path mailbox.
package mmio_map_pkg;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0200_0000;

   localparam logic [7:0] OFS_START = 8'h00;
   localparam logic [7:0] OFS_END   = 8'h04;
   localparam logic [7:0] OFS_NODE  = 8'h08;
   localparam logic [7:0] OFS_DONE  = 8'h0C;
   localparam logic [7:0] OFS_PREV  = 8'h10;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/path_expect_ram.sv
// Expected node-point table: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module path_expect_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // table write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/mmio_path_monitor.sv
// Snoops CPU stores to the path mailbox, checks NODE writes against a
// preloaded expected sequence and reports pass/fail on the CPU's DONE write.
module mmio_path_monitor
   import mmio_map_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                DEPTH     = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEFAULT),
   parameter int                ERR_W     = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       exp_we,
   input  logic [DATA_W-1:0]          exp_data,
   input  logic                       arm,
   input  logic                       MemWrite,
   input  logic [ADDR_W-1:0]          DataAdr,
   input  logic [DATA_W-1:0]          WriteData,
   output logic [DATA_W-1:0]          rotations,
   output logic [$clog2(DEPTH):0]     node_count,
   output logic [ERR_W-1:0]           error_count,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
   localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0]  ERR_ZERO  = {ERR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADR_START = BASE_ADDR + ADDR_W'(OFS_START);
   localparam logic [ADDR_W-1:0] ADR_NODE  = BASE_ADDR + ADDR_W'(OFS_NODE);
   localparam logic [ADDR_W-1:0] ADR_DONE  = BASE_ADDR + ADDR_W'(OFS_DONE);

   state_e            state_q, state_d;
   logic [CW-1:0]     exp_count_q, exp_count_d;
   logic [CW-1:0]     node_count_q, node_count_d;
   logic [ERR_W-1:0]  error_count_q, error_count_d;
   logic [DATA_W-1:0] rotations_q, rotations_d;
   logic              overflow_q, overflow_d;
   logic              pass_q, pass_d;
   logic              busy_q, done_q;

   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;
   logic              hit_start, hit_node, hit_done, mismatch;

   path_expect_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_expect_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (exp_count_q[AW-1:0]),
      .wdata (exp_data),
      .raddr (node_count_q[AW-1:0]),
      .rdata (ram_rdata)
   );

   // END and PREV stores decode as mailbox traffic but change nothing here.
   assign hit_start = MemWrite && (DataAdr == ADR_START);
   assign hit_node  = MemWrite && (DataAdr == ADR_NODE);
   assign hit_done  = MemWrite && (DataAdr == ADR_DONE) && (WriteData == DATA_W'(1));

   // next-state: table load, NODE compare, saturating counters, pass capture
   always_comb begin
      state_d       = state_q;
      exp_count_d   = exp_count_q;
      node_count_d  = node_count_q;
      error_count_d = error_count_q;
      rotations_d   = rotations_q;
      overflow_d    = overflow_q;
      pass_d        = pass_q;
      ram_we        = 1'b0;
      mismatch      = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (exp_we) begin
               if (exp_count_q == DEPTH_C) begin
                  overflow_d = 1'b1;
               end else begin
                  ram_we      = 1'b1;
                  exp_count_d = exp_count_q + CW'(1);
               end
            end else begin
               ram_we = 1'b0;
            end
            if (arm) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (hit_start) begin
               rotations_d = WriteData;
            end else begin
               rotations_d = rotations_q;
            end
            if (hit_node) begin
               if (node_count_q < exp_count_q) begin
                  mismatch = (WriteData != ram_rdata);
               end else begin
                  mismatch   = 1'b1;
                  overflow_d = 1'b1;
               end
               node_count_d  = (node_count_q == DEPTH_C) ? node_count_q : node_count_q + CW'(1);
               error_count_d = (mismatch && (error_count_q != ERR_MAX)) ?
                               error_count_q + ERR_W'(1) : error_count_q;
            end else begin
               mismatch = 1'b0;
            end
            // pass uses post-compare values so a same-edge NODE result is never lost
            if (hit_done) begin
               state_d = ST_DONE;
               pass_d  = (error_count_d == ERR_ZERO) && (node_count_d != {CW{1'b0}}) &&
                         (node_count_d == exp_count_q) && !overflow_d;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // state and registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_LOAD;
         exp_count_q   <= {CW{1'b0}};
         node_count_q  <= {CW{1'b0}};
         error_count_q <= ERR_ZERO;
         rotations_q   <= {DATA_W{1'b0}};
         overflow_q    <= 1'b0;
         pass_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         exp_count_q   <= exp_count_d;
         node_count_q  <= node_count_d;
         error_count_q <= error_count_d;
         rotations_q   <= rotations_d;
         overflow_q    <= overflow_d;
         pass_q        <= pass_d;
         busy_q        <= (state_d == ST_RUN);
         done_q        <= (state_d == ST_DONE);
      end
   end

   assign rotations   = rotations_q;
   assign node_count  = node_count_q;
   assign error_count = error_count_q;
   assign overflow    = overflow_q;
   assign pass        = pass_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
